// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver with COM-symbol byte alignment, feeding the 8->32 demux.
// Optional off-boundary realignment in ACTIVE when SERIAL_PARALELO_REALIGN_EN is defined.
module serial_paralelo_rx #(
   parameter logic [7:0]  COM_SYM   = 8'hBC,
   parameter int unsigned COM_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);

   localparam logic [3:0] COM_CNT_L = 4'(COM_COUNT);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      ALIGN  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t     state_q;
   logic [7:0] sr_q;
   logic [2:0] bit_cnt_q;
   logic [3:0] com_cnt_q;
`ifdef SERIAL_PARALELO_REALIGN_EN
   logic       pend_q;
   logic [2:0] pend_ph_q;
   logic [2:0] pend_age_q;
`endif

   logic [7:0] win;
   logic       boundary;
   logic       match;

   assign win      = {sr_q[6:0], data_in};
   assign boundary = (bit_cnt_q == 3'd7);
   assign match    = (win == COM_SYM);

   // Shift, phase tracking and alignment FSM with registered outputs.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_q    <= SEARCH;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         com_cnt_q  <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         active     <= 1'b0;
`ifdef SERIAL_PARALELO_REALIGN_EN
         pend_q     <= 1'b0;
         pend_ph_q  <= '0;
         pend_age_q <= '0;
`endif
      end else begin
         sr_q      <= win;
         bit_cnt_q <= bit_cnt_q + 3'd1;
         case (state_q)
            SEARCH: begin
               if (match) begin
                  bit_cnt_q <= '0;
                  com_cnt_q <= 4'd1;
                  if (COM_COUNT == 1) begin
                     state_q   <= ACTIVE;
                     active    <= 1'b1;
                     data_out  <= win;
                     valid_out <= 1'b0;
                  end else begin
                     state_q <= ALIGN;
                  end
               end
            end
            ALIGN: begin
               if (boundary) begin
                  if (match) begin
                     com_cnt_q <= com_cnt_q + 4'd1;
                     if ((com_cnt_q + 4'd1) >= COM_CNT_L) begin
                        state_q   <= ACTIVE;
                        active    <= 1'b1;
                        data_out  <= win;
                        valid_out <= 1'b0;
                     end
                  end else begin
                     state_q   <= SEARCH;
                     com_cnt_q <= '0;
                  end
               end
            end
            ACTIVE: begin
               if (boundary) begin
                  data_out  <= win;
                  valid_out <= !match;
               end
`ifdef SERIAL_PARALELO_REALIGN_EN
               // A pending off-boundary COM expires after 8 edges unless repeated at the same phase.
               if (pend_q) begin
                  pend_age_q <= pend_age_q + 3'd1;
                  if (pend_age_q == 3'd7) pend_q <= 1'b0;
               end
               if (match && !boundary) begin
                  if (pend_q && (pend_age_q == 3'd7) && (pend_ph_q == bit_cnt_q)) begin
                     state_q   <= ALIGN;
                     com_cnt_q <= 4'd2;
                     bit_cnt_q <= '0;
                     active    <= 1'b0;
                     valid_out <= 1'b0;
                     pend_q    <= 1'b0;
                  end else begin
                     pend_q     <= 1'b1;
                     pend_ph_q  <= bit_cnt_q;
                     pend_age_q <= '0;
                  end
               end
`endif
            end
            default: state_q <= SEARCH;
         endcase
      end
   end

endmodule
